// File: rtl/execution_tb_ace_intf_addr_pack.sv
// Coalesces per-beat addresses into ACE INCR address-channel bursts (never crossing 4KB).
// Optional idle-flush of a partial burst: define EXECUTION_TB_ACE_PACK_TIMEOUT_EN.
module execution_tb_ace_intf_addr_pack #(
   parameter int ADDR_WIDTH = 32,
   parameter int MAX_LEN    = 16,
   parameter int TIMEOUT    = 15
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_WIDTH-1:0] pk_addr_i,
   input  logic [2:0]            pk_size_i,
   input  logic [2:0]            pk_prot_i,
   input  logic                  pk_last_i,
   input  logic                  pk_valid_i,
   output logic                  pk_ready_o,
   output logic [ADDR_WIDTH-1:0] ace_axaddr_o,
   output logic [2:0]            ace_axsize_o,
   output logic [1:0]            ace_axburst_o,
   output logic [7:0]            ace_axlen_o,
   output logic [2:0]            ace_axprot_o,
   output logic                  ace_axvalid_o,
   input  logic                  ace_axready_i
);

   typedef enum logic [1:0] {IDLE, COLLECT, ISSUE} state_t;

   localparam logic [8:0]            LAST_LEN       = 9'(MAX_LEN - 1);
   localparam bit                    SINGLE_BEAT    = (MAX_LEN == 1);
   localparam logic [7:0]            TIMEOUT_CYCLES = 8'(TIMEOUT);
   localparam logic [ADDR_WIDTH-1:0] ONE            = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   state_t                  state_reg, state_next;
   logic [ADDR_WIDTH-1:0]   base_reg, expected_reg;
   logic [2:0]              size_reg, prot_reg;
   logic [7:0]              len_reg;
   logic [ADDR_WIDTH-1:0]   beat_bytes, reg_bytes, aligned_addr;
   logic                    beat_match, beat_accept, len_full, timeout_hit;

   assign beat_bytes   = ONE << pk_size_i;
   assign reg_bytes    = ONE << size_reg;
   assign aligned_addr = pk_addr_i & ~(beat_bytes - ONE);

   // Upper-bits compare keeps every burst inside one 4KB page.
   assign beat_match = (pk_addr_i == expected_reg) && (pk_size_i == size_reg) &&
                       (pk_prot_i == prot_reg) &&
                       (pk_addr_i[ADDR_WIDTH-1:12] == base_reg[ADDR_WIDTH-1:12]);
   assign beat_accept = pk_valid_i && pk_ready_o;
   assign len_full    = ({1'b0, len_reg} + 9'd1) == LAST_LEN;

`ifdef EXECUTION_TB_ACE_PACK_TIMEOUT_EN
   logic [7:0] idle_cnt_reg;

   always_ff @(posedge clk) begin
      if (!reset_n || state_reg != COLLECT || beat_accept)
         idle_cnt_reg <= 8'd0;
      else if (!pk_valid_i)
         idle_cnt_reg <= idle_cnt_reg + 8'd1;
   end

   assign timeout_hit = (state_reg == COLLECT) && (idle_cnt_reg == TIMEOUT_CYCLES);
`else
   // No idle flush in this build; TIMEOUT is never zero so this stays low.
   assign timeout_hit = (TIMEOUT_CYCLES == 8'd0);
`endif

   always_ff @(posedge clk) begin
      if (!reset_n)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (beat_accept)
               state_next = (pk_last_i || SINGLE_BEAT) ? ISSUE : COLLECT;
         end
         COLLECT: begin
            if (beat_accept)
               state_next = (pk_last_i || len_full) ? ISSUE : COLLECT;
            else if (pk_valid_i || timeout_hit)
               state_next = ISSUE;
         end
         ISSUE: begin
            if (ace_axready_i)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      pk_ready_o    = 1'b0;
      ace_axvalid_o = 1'b0;
      if (reset_n) begin
         case (state_reg)
            IDLE:    pk_ready_o    = 1'b1;
            COLLECT: pk_ready_o    = beat_match;
            ISSUE:   ace_axvalid_o = 1'b1;
            default: pk_ready_o    = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         base_reg     <= '0;
         expected_reg <= '0;
         size_reg     <= 3'd0;
         prot_reg     <= 3'd0;
         len_reg      <= 8'd0;
      end else if (beat_accept && state_reg == IDLE) begin
         base_reg     <= pk_addr_i;
         expected_reg <= aligned_addr + beat_bytes;
         size_reg     <= pk_size_i;
         prot_reg     <= pk_prot_i;
         len_reg      <= 8'd0;
      end else if (beat_accept && state_reg == COLLECT) begin
         expected_reg <= expected_reg + reg_bytes;
         len_reg      <= len_reg + 8'd1;
      end
   end

   assign ace_axaddr_o  = base_reg;
   assign ace_axsize_o  = size_reg;
   assign ace_axprot_o  = prot_reg;
   assign ace_axlen_o   = len_reg;
   assign ace_axburst_o = 2'b01;

endmodule
